// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/global flushes and
// the fixed-latency HI/LO multiply/divide hold-and-release sequence.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_all,
  input  logic       ex_valid,
  input  logic       ex_branch_taken,
  input  logic       ex_muldiv,
  input  logic       ex_memtoreg,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_wbregnum,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       ifid_clr,
  output logic       idex_clr,
  output logic       exmem_clr,
  output logic       md_start,
  output logic       md_busy,
  output logic       hilo_we,
  output logic       md_abort
);

  typedef enum logic [1:0] {StRun, StMdBusy, StMdDone} state_e;

  state_e             state_q, state_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic               luh;

  // Load in EX whose destination is read by the instruction in ID.
  assign luh = ex_valid && ex_memtoreg && ex_regwrite && (ex_wbregnum != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_wbregnum)) ||
                (id_uses_rt && (id_rt == ex_wbregnum)));

  // State and mul/div counter, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and combinational stage-register controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    hilo_we   = 1'b0;
    md_abort  = 1'b0;

    if (!rst_n) begin
      // Hold every stage register cleared while reset is asserted.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      state_d   = StRun;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (flush_all) begin
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
          end else if (ex_valid && ex_branch_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (ex_valid && ex_muldiv) begin
            md_start  = 1'b1;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
            cnt_d     = CNT_W'(MD_CYCLES - 1);
            state_d   = (MD_CYCLES == 1) ? StMdDone : StMdBusy;
          end else if (luh) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end
        end
        StMdBusy: begin
          md_busy   = 1'b1;
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_clr = 1'b1;
          if (flush_all) begin
            md_abort = 1'b1;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            cnt_d    = '0;
            state_d  = StRun;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StMdDone;
          end
        end
        StMdDone: begin
          state_d = StRun;
          if (flush_all) begin
            md_abort  = 1'b1;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
          end else begin
            hilo_we = 1'b1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule
